fir_sample_fifo: RTL and testbench

- Producer side of the FIR input sample FIFO.
- Accepts input samples on the PushIn/DataIn strobe and buffers them in a DEPTH-entry circular store.
- Presents a first-word-fall-through head word, fifo_empty and a pull strobe (fifoPullOut) to the FIR control FSM.
- Flushes on coefficient reload (PushCoef) and reports occupancy, full/almost-full and sticky overflow.

---
 rtl/fir_sample_fifo.sv | 110 +++++++++++
 tb/tb_fir_sample_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_fifo.sv
// fir_sample_fifo: producer-side input sample FIFO for the FIR filter.
// Circular store of DEPTH words with first-word-fall-through head, flush on
// coefficient reload, registered occupancy counter, full/almost-full status
// and a sticky overflow flag for dropped pushes.
module fir_sample_fifo #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     PushIn,
  input  logic [DATA_W-1:0]        DataIn,
  input  logic                     PushCoef,
  input  logic                     fifoPullOut,
  output logic [DATA_W-1:0]        fifo_dout,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic pull_ok;
  logic push_ok;
  logic mem_we;

  // Accept decisions: a pull needs data; a push needs room, or a pull that
  // frees a slot in the same cycle. A flush overrides both.
  always_comb begin
    pull_ok = fifoPullOut && (count_q != '0);
    push_ok = PushIn && ((count_q < DEPTH_C) || pull_ok);
    mem_we  = push_ok && !PushCoef;
  end

  // Next-state: flush first, otherwise pointer/count update and overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (PushCoef) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pull_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pull_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      // Only reachable when full with no pull: the word is dropped.
      if (PushIn && !push_ok) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Sample storage; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[wr_ptr_q] <= DataIn;
    end
  end

  // Status and head word, all derived from registered state only.
  always_comb begin
    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == DEPTH_C);
    almost_full = (count_q >= AF_C);
    overflow    = overflow_q;
    count       = count_q;
    fifo_dout   = fifo_empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_fir_sample_fifo.sv
// Directed testbench for fir_sample_fifo (DEPTH=8, AF_LEVEL=6, DATA_W=32).
module tb_fir_sample_fifo;

  logic        clk;
  logic        reset;
  logic        PushIn;
  logic [31:0] DataIn;
  logic        PushCoef;
  logic        fifoPullOut;
  logic [31:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_full;
  logic        almost_full;
  logic        overflow;
  logic [3:0]  count;

  int total;
  int bad;

  fir_sample_fifo #(.DATA_W(32), .DEPTH(8), .AF_LEVEL(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .PushIn      (PushIn),
    .DataIn      (DataIn),
    .PushCoef    (PushCoef),
    .fifoPullOut (fifoPullOut),
    .fifo_dout   (fifo_dout),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports one check.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // One clock cycle with the given inputs; outputs settle 1 time unit later.
  task automatic cyc(input logic push, input logic [31:0] d, input logic pull, input logic coef);
    PushIn      = push;
    DataIn      = d;
    fifoPullOut = pull;
    PushCoef    = coef;
    @(posedge clk);
    #1;
    PushIn      = 1'b0;
    DataIn      = '0;
    fifoPullOut = 1'b0;
    PushCoef    = 1'b0;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    PushIn      = 1'b0;
    DataIn      = '0;
    PushCoef    = 1'b0;
    fifoPullOut = 1'b0;

    // Reset state
    #2;
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_dout", fifo_dout, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic push/pull ordering
    cyc(1'b1, 32'h11, 1'b0, 1'b0);
    check("t1_dout_lat", fifo_dout, 32'h11);
    check("t1_empty", 32'(fifo_empty), 32'd0);
    cyc(1'b1, 32'h22, 1'b0, 1'b0);
    cyc(1'b1, 32'h33, 1'b0, 1'b0);
    check("t1_count3", 32'(count), 32'd3);
    check("t1_head0", fifo_dout, 32'h11);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("t1_head1", fifo_dout, 32'h22);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("t1_head2", fifo_dout, 32'h33);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("t1_empty_end", 32'(fifo_empty), 32'd1);
    check("t1_count_end", 32'(count), 32'd0);
    check("t1_dout_end", fifo_dout, 32'h0);

    // Fill to full, almost_full threshold, overflow
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
      check("t2_count", 32'(count), 32'(i + 1));
      check("t2_af", 32'(almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
      check("t2_full", 32'(fifo_full), (i + 1 == 8) ? 32'd1 : 32'd0);
    end
    check("t2_ovf_before", 32'(overflow), 32'd0);
    cyc(1'b1, 32'hFF, 1'b0, 1'b0);
    check("t2_ovf", 32'(overflow), 32'd1);
    check("t2_count_ovf", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("t2_drain", fifo_dout, 32'hA0 + 32'(i));
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
    end
    check("t2_empty", 32'(fifo_empty), 32'd1);
    check("t2_ovf_sticky", 32'(overflow), 32'd1);

    // Full with simultaneous push+pull
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    check("t3_full", 32'(fifo_full), 32'd1);
    check("t3_head_before", fifo_dout, 32'hA0);
    cyc(1'b1, 32'hB8, 1'b1, 1'b0);
    check("t3_count", 32'(count), 32'd8);
    check("t3_head_after", fifo_dout, 32'hA1);
    for (int i = 0; i < 8; i++) begin
      check("t3_drain", fifo_dout, (i == 7) ? 32'hB8 : 32'hA1 + 32'(i));
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
    end
    check("t3_empty", 32'(fifo_empty), 32'd1);

    // Wrap-around at steady occupancy 4
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      check("t3w_head", fifo_dout, 32'hC0 + 32'(i));
      cyc(1'b1, 32'hC4 + 32'(i), 1'b1, 1'b0);
      check("t3w_count", 32'(count), 32'd4);
    end
    for (int i = 0; i < 4; i++) begin
      check("t3w_drain", fifo_dout, 32'hD4 + 32'(i));
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
    end
    check("t3w_empty", 32'(fifo_empty), 32'd1);

    // Empty with push+pull; pull on empty
    cyc(1'b1, 32'h55, 1'b1, 1'b0);
    check("t4_count", 32'(count), 32'd1);
    check("t4_dout", fifo_dout, 32'h55);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("t4_empty", 32'(fifo_empty), 32'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("t4_underflow_cnt", 32'(count), 32'd0);
    check("t4_underflow_empty", 32'(fifo_empty), 32'd1);
    cyc(1'b1, 32'h66, 1'b0, 1'b0);
    check("t4_noptrmove", fifo_dout, 32'h66);
    check("t4_count1", 32'(count), 32'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with push in the same cycle
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h70 + 32'(i), 1'b0, 1'b0);
    check("t5_count5", 32'(count), 32'd5);
    check("t5_ovf_set", 32'(overflow), 32'd1);
    cyc(1'b1, 32'h77, 1'b0, 1'b1);
    check("t5_count0", 32'(count), 32'd0);
    check("t5_empty", 32'(fifo_empty), 32'd1);
    check("t5_ovf_clr", 32'(overflow), 32'd0);
    check("t5_dout0", fifo_dout, 32'h0);
    cyc(1'b1, 32'h88, 1'b0, 1'b0);
    check("t5_head", fifo_dout, 32'h88);
    check("t5_count1", 32'(count), 32'd1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h90 + 32'(i), 1'b0, 1'b0);
    check("t6_count4", 32'(count), 32'd4);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_count", 32'(count), 32'd0);
    check("t6_async_empty", 32'(fifo_empty), 32'd1);
    check("t6_async_dout", fifo_dout, 32'h0);
    check("t6_async_af", 32'(almost_full), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b1, 32'h99, 1'b0, 1'b0);
    check("t6_head", fifo_dout, 32'h99);
    check("t6_count1", 32'(count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
